// File: rtl/maze_pkg.sv
// Shared encodings for the maze solver/checker pair: moves, error codes, FSM states, address packing.
// Pure declarations; no timing or flow control of its own.
package maze_pkg;

   localparam logic [1:0] MV_UP    = 2'b00;
   localparam logic [1:0] MV_RIGHT = 2'b01;
   localparam logic [1:0] MV_LEFT  = 2'b10;
   localparam logic [1:0] MV_DOWN  = 2'b11;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_WALL    = 2'b01;
   localparam logic [1:0] ERR_RANGE   = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD   = 3'd1,
      ST_EVAL = 3'd2,
      ST_WAIT = 3'd3,
      ST_PASS = 3'd4,
      ST_FAIL = 3'd5
   } state_t;

   // Row-major {y, x}; callers truncate the result to 2*n bits.
   function automatic logic [31:0] pack_addr(input logic [15:0] x, input logic [15:0] y,
                                             input int unsigned n);
      return ({16'b0, y} << n) | {16'b0, x};
   endfunction

endpackage

// File: rtl/maze_step_decode.sv
// Applies one 2-bit move to (x, y) and flags a step off the grid; purely combinational.
// Zero latency, no flow control.
module maze_step_decode
   import maze_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0] x,
   input  logic [N-1:0] y,
   input  logic [1:0]   move,
   output logic [N-1:0] nx,
   output logic [N-1:0] ny,
   output logic         out_of_range
);

   logic [N:0] ex;
   logic [N:0] ey;

   // One extra bit: -1 and 2^N both land with the top bit set.
   always_comb begin
      ex = {1'b0, x};
      ey = {1'b0, y};
      case (move)
         MV_UP:    ey = ey - (N+1)'(1);
         MV_RIGHT: ex = ex + (N+1)'(1);
         MV_LEFT:  ex = ex - (N+1)'(1);
         MV_DOWN:  ey = ey + (N+1)'(1);
         default:  ex = {1'b0, x};
      endcase
   end

   assign nx           = ex[N-1:0];
   assign ny           = ey[N-1:0];
   assign out_of_range = ex[N] | ey[N];

endmodule

// File: rtl/maze_path_checker.sv
// Replays a move stream against the maze memory and reports pass/fail with an error code.
// 3 cycles per legal move (transfer, read, evaluate); move_ready only in WAIT, no buffering.
module maze_path_checker
   import maze_pkg::*;
#(
   parameter int N         = 4,
   parameter int START_X   = 0,
   parameter int START_Y   = 0,
   parameter int GOAL_X    = (1 << N) - 1,
   parameter int GOAL_Y    = (1 << N) - 1,
   parameter int MAX_STEPS = 255
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic           move_valid,
   input  logic [1:0]     move,
   output logic           move_ready,
   output logic           mem_rd,
   output logic [2*N-1:0] mem_addr,
   input  logic           mem_dout,
   output logic [N-1:0]   x_o,
   output logic [N-1:0]   y_o,
   output logic [7:0]     step_cnt,
   output logic           busy,
   output logic           pass,
   output logic           fail,
   output logic [1:0]     err
);

   localparam logic [N-1:0] SX = N'(START_X);
   localparam logic [N-1:0] SY = N'(START_Y);
   localparam logic [N-1:0] GX = N'(GOAL_X);
   localparam logic [N-1:0] GY = N'(GOAL_Y);
   localparam logic [7:0]   MAX_CNT = 8'(MAX_STEPS);

   state_t       state;
   logic [N-1:0] cand_x;
   logic [N-1:0] cand_y;
   logic         probe_move;
   logic [N-1:0] nx;
   logic [N-1:0] ny;
   logic         oor;

   maze_step_decode #(.N(N)) u_decode (
      .x            (x_o),
      .y            (y_o),
      .move         (move),
      .nx           (nx),
      .ny           (ny),
      .out_of_range (oor)
   );

   assign move_ready = (state == ST_WAIT);
   assign mem_rd     = (state == ST_RD);
   assign busy       = (state == ST_RD) || (state == ST_EVAL) || (state == ST_WAIT);
   assign mem_addr   = (state == ST_RD) ?
                       (2*N)'(pack_addr(16'(cand_x), 16'(cand_y), N)) : '0;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= ST_IDLE;
         x_o        <= SX;
         y_o        <= SY;
         cand_x     <= SX;
         cand_y     <= SY;
         probe_move <= 1'b0;
         step_cnt   <= '0;
         pass       <= 1'b0;
         fail       <= 1'b0;
         err        <= ERR_NONE;
      end else begin
         case (state)
            ST_IDLE, ST_PASS, ST_FAIL: begin
               if (start) begin
                  x_o        <= SX;
                  y_o        <= SY;
                  cand_x     <= SX;
                  cand_y     <= SY;
                  probe_move <= 1'b0;
                  step_cnt   <= '0;
                  pass       <= 1'b0;
                  fail       <= 1'b0;
                  err        <= ERR_NONE;
                  state      <= ST_RD;
               end
            end
            ST_RD: state <= ST_EVAL;
            ST_EVAL: begin
               if (mem_dout) begin
                  err   <= ERR_WALL;
                  fail  <= 1'b1;
                  state <= ST_FAIL;
               end else begin
                  if (probe_move) begin
                     x_o      <= cand_x;
                     y_o      <= cand_y;
                     step_cnt <= step_cnt + 8'd1;
                  end
                  // The start probe's candidate is the current position, so one compare covers both.
                  if (cand_x == GX && cand_y == GY) begin
                     pass  <= 1'b1;
                     state <= ST_PASS;
                  end else begin
                     state <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               if (move_valid) begin
                  if (oor) begin
                     err   <= ERR_RANGE;
                     fail  <= 1'b1;
                     state <= ST_FAIL;
                  end else if (step_cnt == MAX_CNT) begin
                     err   <= ERR_TIMEOUT;
                     fail  <= 1'b1;
                     state <= ST_FAIL;
                  end else begin
                     cand_x     <= nx;
                     cand_y     <= ny;
                     probe_move <= 1'b1;
                     state      <= ST_RD;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/maze_path_checker.md
# maze_path_checker

Consumes a stream of 2-bit rat moves and replays them against the maze memory, tracking the rat's coordinates. It asserts `pass` when the replayed path legally reaches the goal cell and `fail` with an error code at the first illegal step. It is the receiving end of the move stream that `rat_in_maze` emits on `move`, and serves as the on-chip path verifier and the replay engine behind `run`.

## Interface
- `N`, 4 — coordinate width; grid is 2^N × 2^N.
- `START_X` / `START_Y`, 0 / 0 — entry cell.
- `GOAL_X` / `GOAL_Y`, 2^N−1 / 2^N−1 — exit cell.
- `MAX_STEPS`, 255 — accepted-move limit before a timeout failure.

- `clk`  in  1 — single clock; all state changes on the rising edge.
- `rst`  in  1 — synchronous, active-low reset.
- `start`  in  1 — begin a new check; honoured only in IDLE, PASS or FAIL.
- `move_valid`  in  1 — `move` carries a step.
- `move`  in  2 — 00 up (y−1), 01 right (x+1), 10 left (x−1), 11 down (y+1).
- `move_ready`  out  1 — high only in WAIT; a move transfers when `move_valid & move_ready`.
- `mem_rd`  out  1 — maze read strobe.
- `mem_addr`  out  2N — `{y, x}` of the cell being probed.
- `mem_dout`  in  1 — wall bit (1 = blocked); valid the cycle after `mem_rd`.
- `x_o`, `y_o`  out  N each — current rat position.
- `step_cnt`  out  8 — accepted legal moves.
- `busy`  out  1 — high in RD, EVAL and WAIT.
- `pass`  out  1 — level; path reached the goal.
- `fail`  out  1 — level; path was illegal.
- `err`  out  2 — 00 none, 01 wall, 10 range, 11 timeout.

## Operation
- Reset values: state IDLE; `x_o`=START_X; `y_o`=START_Y; `step_cnt`, `pass`, `fail`, `err`, `mem_rd`, `move_ready`, `busy` all 0; `mem_addr` 0.
- FSM states: IDLE, RD, EVAL, WAIT, PASS, FAIL.
- **IDLE/PASS/FAIL** on `start`:
  - load position START;
  - clear `step_cnt`, `pass`, `fail`, `err`;
  - candidate := START; go to RD.
- **RD**: `mem_rd`=1, `mem_addr`=candidate. Next state EVAL.
- **EVAL**: sample `mem_dout`.
  - Wall: `err`=01, go to FAIL. Position is unchanged.
  - Open, probe was a move: position := candidate and `step_cnt`++.
  - Open, probe was the start cell: position is unchanged and `step_cnt` is not incremented.
  - Then go to PASS if position equals the goal, else WAIT.
- **WAIT** on a transfer, the next candidate is decoded:
  - If it under- or overflows the grid (x or y leaves 0..2^N−1), set `err`=10 and go to FAIL.
  - Otherwise, if `step_cnt` equals MAX_STEPS, set `err`=11 and go to FAIL.
  - Otherwise go to RD.
- Coordinates use N+1-bit arithmetic for the range check and do not wrap. `step_cnt` never exceeds MAX_STEPS.
- `pass`/`fail` hold until the next accepted `start` or reset. `start` is ignored in RD, EVAL and WAIT.
- `move_valid` outside WAIT is ignored (no buffering).

## Timing
- Per legal move: transfer in WAIT at cycle t; RD at t+1; EVAL at t+2; position update and re-entry to WAIT (or PASS) visible at t+3.
- Throughput is one move per 3 cycles.
- Range or timeout failure: `fail` is high at t+1 with no memory read.
- Start probe: `start` at cycle s; `mem_rd` at s+1; WAIT or FAIL at s+3.
- Reset asserted in any state: IDLE with reset values on the next edge. An in-flight `mem_dout` is discarded.
- Simultaneous `start` and `move_valid` in IDLE: `start` wins and the move is dropped.

## Structure
- Shared package `maze_pkg`:
  - move encodings;
  - `err` codes;
  - FSM state enum;
  - `{y, x}` address packing function.
- One sub-module, `maze_step_decode`: combinational; takes (x, y, move) and produces (nx, ny, out_of_range). It is reusable by the solver.
- The FSM and registers stay in the top level.

## Test plan
- Open 16×16 maze, start, 15 × `01` then 15 × `11` → `pass`=1, `err`=00, `step_cnt`=30, `x_o`=`y_o`=15, `fail`=0.
- Wall at (x=2, y=0); moves `01`,`01` → `fail`=1, `err`=01, `x_o`=1, `y_o`=0, `step_cnt`=1, two cycles after the second RD.
- At (0,0), move `00` → `fail`=1, `err`=10 one cycle after the transfer, `mem_rd` never asserted for it.
- MAX_STEPS=4, open maze, moves `01`,`10` ×3 → the fifth move fails with `err`=11, `step_cnt`=4.
- Wall at START → `fail`=1, `err`=01 at s+3, `move_ready` never high; a following `start` with the wall removed reaches WAIT.
- Reset low during EVAL mid-path → next edge: IDLE, `x_o`=`y_o`=0, `busy`=0; `move_valid` pulses before `start` are ignored.
